// File: rtl/ddr_port_arbiter_if.sv
// MIG 7-series user (app_*) command/data bundle between the port arbiter and mig_7series_0.
// master = arbiter side, slave = MIG side.
interface ddr_port_arbiter_if #(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 128
);
  logic [ADDR_WIDTH-1:0]   app_addr;
  logic [2:0]              app_cmd;
  logic                    app_en;
  logic                    app_rdy;
  logic [DATA_WIDTH-1:0]   app_wdf_data;
  logic [DATA_WIDTH/8-1:0] app_wdf_mask;
  logic                    app_wdf_wren;
  logic                    app_wdf_end;
  logic                    app_wdf_rdy;
  logic [DATA_WIDTH-1:0]   app_rd_data;
  logic                    app_rd_data_valid;

  modport master (
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
  );

  modport slave (
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
  );
endinterface

// File: rtl/ddr_port_arbiter.sv
// N-port arbiter/sequencer in front of the MIG app interface (ui_clk domain).
// Define DDR_ARB_ROUND_ROBIN_EN for round-robin; otherwise fixed priority, lowest port wins.
module ddr_port_arbiter #(
  parameter int NUM_PORTS  = 3,
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 128,
  parameter int MAX_BEATS  = 4
) (
  input  logic                              clk_166M66,
  input  logic                              mcu_sys_rst,
  input  logic                              i_init_calib_complete,
  input  logic [NUM_PORTS-1:0]              i_req,
  input  logic [NUM_PORTS-1:0]              i_rw,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   i_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   i_wdata,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] i_wmask,
  output logic [NUM_PORTS-1:0]              o_grant,
  output logic [NUM_PORTS-1:0]              o_ack,
  output logic [DATA_WIDTH-1:0]             o_rdata,
  output logic [NUM_PORTS-1:0]              o_rvalid,
  output logic                              o_busy,
  ddr_port_arbiter_if.master                app
);
  localparam int OW     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW     = $clog2(MAX_BEATS + 1);
  localparam int MASK_W = DATA_WIDTH / 8;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ARB     = 3'd1;
  localparam logic [2:0] S_ISSUE   = 3'd2;
  localparam logic [2:0] S_RD_WAIT = 3'd3;
  localparam logic [2:0] S_NEXT    = 3'd4;

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  logic [2:0]            r_state;
  logic [OW-1:0]         r_owner;
  logic [CW-1:0]         r_beats;
  logic [NUM_PORTS-1:0]  r_grant;
  logic [NUM_PORTS-1:0]  r_ack;
  logic [NUM_PORTS-1:0]  r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [ADDR_WIDTH-1:0] r_app_addr;
  logic [2:0]            r_app_cmd;
  logic                  r_app_en;
  logic [DATA_WIDTH-1:0] r_wdf_data;
  logic [MASK_W-1:0]     r_wdf_mask;
  logic                  r_wdf_wren;
`ifdef DDR_ARB_ROUND_ROBIN_EN
  logic [OW-1:0]         r_ptr;
  int unsigned           w_idx;
`endif

  logic [ADDR_WIDTH-1:0] w_addr  [NUM_PORTS];
  logic [DATA_WIDTH-1:0] w_wdata [NUM_PORTS];
  logic [MASK_W-1:0]     w_wmask [NUM_PORTS];
  logic [OW-1:0]         w_win;
  logic                  w_any;
  logic [OW-1:0]         w_sel;
  logic                  w_arb_go;
  logic                  w_next_go;
  logic                  w_cmd_ok;
  logic                  w_wdf_ok;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
    assign w_addr[g]  = i_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wdata[g] = i_wdata[g*DATA_WIDTH +: DATA_WIDTH];
    assign w_wmask[g] = i_wmask[g*MASK_W +: MASK_W];
  end

  always_comb begin
    w_win = '0;
    w_any = 1'b0;
`ifdef DDR_ARB_ROUND_ROBIN_EN
    w_idx = 0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      w_idx = (32'(r_ptr) + i) % NUM_PORTS;
      if (!w_any && i_req[OW'(w_idx)]) begin
        w_any = 1'b1;
        w_win = OW'(w_idx);
      end
    end
`else
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (!w_any && i_req[OW'(i)]) begin
        w_any = 1'b1;
        w_win = OW'(i);
      end
    end
`endif
  end

  assign w_arb_go  = (r_state == S_ARB) && w_any && i_init_calib_complete;
  assign w_next_go = (r_state == S_NEXT) && i_req[r_owner] && (r_beats < CW'(MAX_BEATS))
                     && i_init_calib_complete;
  assign w_sel     = (r_state == S_ARB) ? w_win : r_owner;
  // A write beat ends once both command and data channels have handshaken, in any order.
  assign w_cmd_ok  = !r_app_en   || app.app_rdy;
  assign w_wdf_ok  = !r_wdf_wren || app.app_wdf_rdy;

  always_ff @(posedge clk_166M66 or posedge mcu_sys_rst) begin
    if (mcu_sys_rst) begin
      r_state    <= S_IDLE;
      r_owner    <= '0;
      r_beats    <= '0;
      r_grant    <= '0;
      r_ack      <= '0;
      r_rvalid   <= '0;
      r_rdata    <= '0;
      r_app_addr <= '0;
      r_app_cmd  <= CMD_RD;
      r_app_en   <= 1'b0;
      r_wdf_data <= '0;
      r_wdf_mask <= '0;
      r_wdf_wren <= 1'b0;
`ifdef DDR_ARB_ROUND_ROBIN_EN
      r_ptr      <= '0;
`endif
    end else begin
      r_ack    <= '0;
      r_rvalid <= '0;
      case (r_state)
        S_IDLE: begin
          if (|i_req && i_init_calib_complete) r_state <= S_ARB;
        end
        S_ARB: begin
          if (w_arb_go) begin
            r_grant <= NUM_PORTS'(1) << w_win;
            r_owner <= w_win;
            r_beats <= '0;
            r_state <= S_ISSUE;
`ifdef DDR_ARB_ROUND_ROBIN_EN
            r_ptr   <= (w_win == OW'(NUM_PORTS - 1)) ? '0 : w_win + 1'b1;
`endif
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          if (r_app_cmd == CMD_WR) begin
            r_app_en   <= r_app_en   && !app.app_rdy;
            r_wdf_wren <= r_wdf_wren && !app.app_wdf_rdy;
            if (w_cmd_ok && w_wdf_ok) begin
              r_ack   <= r_grant;
              r_beats <= r_beats + CW'(1);
              r_state <= S_NEXT;
            end
          end else if (app.app_rdy) begin
            r_app_en <= 1'b0;
            r_state  <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (app.app_rd_data_valid) begin
            r_rdata  <= app.app_rd_data;
            r_rvalid <= r_grant;
            r_ack    <= r_grant;
            r_beats  <= r_beats + CW'(1);
            r_state  <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (w_next_go) begin
            r_state <= S_ISSUE;
          end else begin
            r_grant <= '0;
            r_state <= (|i_req && i_init_calib_complete) ? S_ARB : S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_arb_go || w_next_go) begin
        r_app_addr <= w_addr[w_sel];
        r_app_cmd  <= i_rw[w_sel] ? CMD_WR : CMD_RD;
        r_app_en   <= 1'b1;
        r_wdf_wren <= i_rw[w_sel];
        r_wdf_data <= w_wdata[w_sel];
        r_wdf_mask <= w_wmask[w_sel];
      end
    end
  end

  assign o_grant          = r_grant;
  assign o_ack            = r_ack;
  assign o_rvalid         = r_rvalid;
  assign o_rdata          = r_rdata;
  assign o_busy           = (r_state != S_IDLE);
  assign app.app_addr     = r_app_addr;
  assign app.app_cmd      = r_app_cmd;
  assign app.app_en       = r_app_en;
  assign app.app_wdf_data = r_wdf_data;
  assign app.app_wdf_mask = r_wdf_mask;
  assign app.app_wdf_wren = r_wdf_wren;
  assign app.app_wdf_end  = r_wdf_wren;
endmodule
